// File: rtl/ram_pkg.sv
// Shared sizing for the RAM-backed FIFO: default word/address widths, depth,
// and the wrapping pointer increment used by both RAM pointers.
package ram_pkg;

  localparam int RAM_DATA_W = 8;
  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DEPTH  = 2 ** RAM_ADDR_W;

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ram_fifo_outbuf.sv
// 2-entry in-order skid buffer on the RAM read side; a load becomes visible the next cycle.
// Load and pop on the same edge are both honoured; the issuer guarantees no overflow.
module ram_fifo_outbuf
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              pop,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic [1:0]        cnt
);

  logic [DATA_W-1:0] r_ent0;
  logic [DATA_W-1:0] r_ent1;
  logic [1:0]        r_cnt;
  logic              w_pop;

  assign w_pop = pop & (r_cnt != 2'd0);
  assign data  = r_ent0;
  assign valid = (r_cnt != 2'd0);
  assign cnt   = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent0 <= '0;
      r_ent1 <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case ({load, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_ent0 <= load_data;
          else               r_ent1 <= load_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_ent0 <= r_ent1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Head leaves while a new word arrives: occupancy is unchanged.
          if (r_cnt == 2'd1) begin
            r_ent0 <= load_data;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/single_port_ram.sv
// 2**ADDR_W x DATA_W RAM: synchronous write, registered read (q valid the cycle after read_addr).
// Contents are never cleared; no flow control.
module single_port_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) r_mem[write_addr] <= data;
    q <= r_mem[read_addr];
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller around an external registered-read RAM; 3-cycle in->out latency, 1 word/cycle.
// in_ready drops when the RAM holds DEPTH words; reads stall when the output buffer would overflow.
module ram_fifo_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W+1:0] count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned     DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_ram_cnt;
  logic              r_rd_pend;

  logic              w_push;
  logic              w_pop;
  logic              w_rd;
  logic              w_out_valid;
  logic [1:0]        w_ob_cnt;
  logic [2:0]        w_occ;

  assign in_ready = (r_ram_cnt < DEPTH_C);
  assign w_push   = in_valid & in_ready;
  assign w_pop    = w_out_valid & out_ready;

  // Words that will sit in the output buffer after this edge, not counting a new read.
  assign w_occ = {1'b0, w_ob_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  assign w_rd  = (r_ram_cnt != '0) && (w_occ < 3'd2);

  assign ram_we         = w_push;
  assign ram_data       = in_data;
  assign ram_write_addr = r_wr_ptr;
  assign ram_read_addr  = r_rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ADDR_W'(ptr_next(32'(r_wr_ptr), DEPTH));
      if (w_rd)   r_rd_ptr <= ADDR_W'(ptr_next(32'(r_rd_ptr), DEPTH));
      r_rd_pend <= w_rd;
      if (w_push && !w_rd)      r_ram_cnt <= r_ram_cnt + (ADDR_W + 1)'(1);
      else if (!w_push && w_rd) r_ram_cnt <= r_ram_cnt - (ADDR_W + 1)'(1);
    end
  end

  ram_fifo_outbuf #(
    .DATA_W (DATA_W)
  ) u_outbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (r_rd_pend),
    .load_data (ram_q),
    .pop       (w_pop),
    .data      (out_data),
    .valid     (w_out_valid),
    .cnt       (w_ob_cnt)
  );

  assign out_valid = w_out_valid;
  assign count     = (ADDR_W + 2)'(r_ram_cnt) + (ADDR_W + 2)'(r_rd_pend) + (ADDR_W + 2)'(w_ob_cnt);
  assign full      = (r_ram_cnt == DEPTH_C);
  assign empty     = (count == '0);

endmodule
